fcc_req_arbiter: RTL and testbench
==================================

Name: fcc_req_arbiter

Overview:
- Round-robin arbiter that shares the single channel-0 request FIFO write port (264-bit request entries) among NUM_REQ independent requesters, e.g. host queue, GC engine and scrub engine.
- Sits in the clk domain in front of the fcc_top request interface.
- Registers the winning entry into a one-deep output slot, stamps the CID with the source index so read data (m_axis tid) can be routed back, and throttles on req_fifo_almost_full.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_BITS, 2, source-index width; must equal clog2(NUM_REQ).
- REQ_W, 264, request entry width; fixed, do not change.
- TAG_CID, "TRUE", when "TRUE" overwrite CID bits [31:32-ID_BITS] with the source index; when "FALSE" pass the entry unmodified.

Ports:
- clk  in  1  request clock domain.
- rst_n  in  1  asynchronous active-low reset.
- s_req_valid  in  NUM_REQ  per-requester entry valid.
- s_req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- s_req_data  in  NUM_REQ*REQ_W  requester i occupies bits [i*REQ_W +: REQ_W].
- m_req_valid  out  1  to i_req_fifo_valid_0.
- m_req_ready  in  1  from o_req_fifo_ready_0.
- m_req_data  out  REQ_W  to i_req_fifo_data_0.
- m_req_src  out  ID_BITS  source index of the entry in the output slot.
- req_fifo_almost_full  in  1  from fcc_top; blocks new accepts.
- o_issued_cnt  out  32  count of completed m_req handshakes; wraps.

Behaviour:
- Reset (async assert, sync release): m_req_valid=0, m_req_data=0, m_req_src=0, o_issued_cnt=0, rr_ptr=0, s_req_ready=0.
- slot_free = !m_req_valid || m_req_ready (output slot empty or draining this cycle).
- can_accept = slot_free && !req_fifo_almost_full.
- Grant selection (combinational): the first i with s_req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - s_req_ready[g]=1 only when can_accept and g is the winner; all other bits are 0.
  - s_req_ready never depends on s_req_valid of any other requester except through the arbitration.
- On accept (s_req_valid[g] && s_req_ready[g]), next cycle:
  - m_req_valid=1.
  - m_req_data = s_req_data[g], with CID bits [31:32-ID_BITS]=g when TAG_CID="TRUE".
  - m_req_src=g.
  - rr_ptr = (g+1) mod NUM_REQ.
- Latency: exactly 1 cycle from accept to m_req_valid. Throughput: 1 entry/cycle while m_req_ready=1 and not almost full.
- Output slot hold rules:
  - While m_req_valid=1 and m_req_ready=0, m_req_data and m_req_src hold stable and no new accept occurs.
  - Handshake with no new accept in the same cycle: m_req_valid drops to 0 next cycle.
  - Handshake with a simultaneous accept: slot reloads with no bubble.
- req_fifo_almost_full=1:
  - No new accepts.
  - An entry already in the slot still presents and may complete; it is never withdrawn.
  - Accepting resumes the first cycle almost_full=0.
- No valid requesters: rr_ptr unchanged, slot drains normally.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.
- o_issued_cnt increments on every m_req_valid && m_req_ready and wraps 0xFFFFFFFF→0.
- Reset mid-operation: the slot entry is discarded and no partial state is kept. Requesters must re-present their entries (their valid/data are held, per handshake rules).
- Requester valid/data must stay stable until ready. The arbiter does not check this.

Decomposition:
- Shared package fcc_pkg:
  - REQ_W=264.
  - CID_MSB=31, CID_LSB=16, OPC_MSB=15, OPC_LSB=0.
  - function clog2.
- Sub-module fcc_rr_pick (parameter N): inputs req[N], ptr, en; outputs gnt one-hot, gnt_idx, any. Purely combinational. rr_ptr and the output slot live in fcc_req_arbiter.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with slot full → m_req_valid=0, o_issued_cnt=0 immediately; after release, first grant goes to requester 0.
- Single requester: req1 presents CID=0x1234, m_req_ready=1 → one cycle later m_req_valid=1, m_req_src=1, CID=0x5234 (TAG_CID="TRUE"); o_issued_cnt=1 after handshake.
- All-four contention: all four continuously valid, m_req_ready=1 → grant order 0,1,2,3,0,1,…, one entry per cycle, no bubbles; 8 cycles give o_issued_cnt=8.
- Backpressure: m_req_ready=0 for 5 cycles with req2 pending → m_req_data stable, s_req_ready all 0. Then m_req_ready=1 → slot handshakes and reloads from req2 in the same cycle.
- Almost-full: almost_full=1 with entry in slot and req3 valid → slot completes, s_req_ready stays 0 until almost_full=0, then req3 is granted the next cycle.
- Pointer wrap: rr_ptr=3, only req0 and req3 valid → req3 granted first, rr_ptr→0, then req0 granted.

Source files
------------

// File: rtl/fcc_pkg.sv
// Shared constants and helpers for the channel request path.
package fcc_pkg;

   localparam int unsigned REQ_W   = 264;
   localparam int unsigned CID_MSB = 31;
   localparam int unsigned CID_LSB = 16;
   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 0;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fcc_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
module fcc_rr_pick
   import fcc_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   logic        found;
   int unsigned pos;

   // Walk from the pointer; the first hit wins.
   always_comb begin
      found   = 1'b0;
      pos     = 0;
      gnt_idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = 32'(ptr) + k;
         if (pos >= N) pos = pos - N;
         if (!found && req[pos]) begin
            found   = 1'b1;
            gnt_idx = IW'(pos);
         end
      end
   end

   assign any = |req;
   assign gnt = (en && found) ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/fcc_req_arbiter.sv
// Round-robin arbiter feeding the channel-0 request FIFO through a one-deep output slot.
module fcc_req_arbiter
   import fcc_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_BITS = 2,
   parameter int unsigned REQ_W   = fcc_pkg::REQ_W,
   parameter string       TAG_CID = "TRUE"
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       s_req_valid,
   output logic [NUM_REQ-1:0]       s_req_ready,
   input  logic [NUM_REQ*REQ_W-1:0] s_req_data,
   output logic                     m_req_valid,
   input  logic                     m_req_ready,
   output logic [REQ_W-1:0]         m_req_data,
   output logic [ID_BITS-1:0]       m_req_src,
   input  logic                     req_fifo_almost_full,
   output logic [31:0]              o_issued_cnt
);

   localparam bit TAG_EN = (TAG_CID == "TRUE");

   logic               m_req_valid_q, m_req_valid_d;
   logic [REQ_W-1:0]   m_req_data_q,  m_req_data_d;
   logic [ID_BITS-1:0] m_req_src_q,   m_req_src_d;
   logic [ID_BITS-1:0] rr_ptr_q,      rr_ptr_d;
   logic [31:0]        issued_cnt_q,  issued_cnt_d;

   logic               can_accept_c;
   logic               any_c;
   logic               accept_c;
   logic               handshake_c;
   logic [ID_BITS-1:0] gnt_idx_c;
   logic [REQ_W-1:0]   entry_c;

   assign handshake_c  = m_req_valid_q && m_req_ready;
   // Grants are suppressed while reset is held so no requester sees ready.
   assign can_accept_c = rst_n && (!m_req_valid_q || m_req_ready) && !req_fifo_almost_full;
   assign accept_c     = can_accept_c && any_c;

   fcc_rr_pick #(
      .N  (NUM_REQ),
      .IW (ID_BITS)
   ) u_pick (
      .req     (s_req_valid),
      .ptr     (rr_ptr_q),
      .en      (can_accept_c),
      .gnt     (s_req_ready),
      .gnt_idx (gnt_idx_c),
      .any     (any_c)
   );

   // Winning entry, with the CID top bits replaced by the source index for return routing.
   always_comb begin
      entry_c = s_req_data[REQ_W*32'(gnt_idx_c) +: REQ_W];
      if (TAG_EN) entry_c[CID_MSB -: ID_BITS] = gnt_idx_c;
   end

   always_comb begin
      m_req_valid_d = m_req_valid_q;
      m_req_data_d  = m_req_data_q;
      m_req_src_d   = m_req_src_q;
      rr_ptr_d      = rr_ptr_q;
      issued_cnt_d  = issued_cnt_q;
      if (handshake_c) begin
         m_req_valid_d = 1'b0;
         issued_cnt_d  = issued_cnt_q + 32'd1;
      end
      if (accept_c) begin
         m_req_valid_d = 1'b1;
         m_req_data_d  = entry_c;
         m_req_src_d   = gnt_idx_c;
         rr_ptr_d      = (gnt_idx_c == ID_BITS'(NUM_REQ - 1)) ? '0 : gnt_idx_c + ID_BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_req_valid_q <= 1'b0;
         m_req_data_q  <= '0;
         m_req_src_q   <= '0;
         rr_ptr_q      <= '0;
         issued_cnt_q  <= '0;
      end else begin
         m_req_valid_q <= m_req_valid_d;
         m_req_data_q  <= m_req_data_d;
         m_req_src_q   <= m_req_src_d;
         rr_ptr_q      <= rr_ptr_d;
         issued_cnt_q  <= issued_cnt_d;
      end
   end

   assign m_req_valid  = m_req_valid_q;
   assign m_req_data   = m_req_data_q;
   assign m_req_src    = m_req_src_q;
   assign o_issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_fcc_req_arbiter.sv
// Bench for fcc_req_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_fcc_req_arbiter;

   localparam int N   = 4;
   localparam int IDB = 2;
   localparam int W   = 264;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     s_req_valid;
   logic [N-1:0]     s_req_ready;
   logic [N*W-1:0]   s_req_data;
   logic             m_req_valid;
   logic             m_req_ready;
   logic [W-1:0]     m_req_data;
   logic [IDB-1:0]   m_req_src;
   logic             af;
   logic [31:0]      o_issued_cnt;

   always #5 clk = ~clk;

   fcc_req_arbiter #(
      .NUM_REQ (N),
      .ID_BITS (IDB),
      .REQ_W   (W),
      .TAG_CID ("TRUE")
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .s_req_valid          (s_req_valid),
      .s_req_ready          (s_req_ready),
      .s_req_data           (s_req_data),
      .m_req_valid          (m_req_valid),
      .m_req_ready          (m_req_ready),
      .m_req_data           (m_req_data),
      .m_req_src            (m_req_src),
      .req_fifo_almost_full (af),
      .o_issued_cnt         (o_issued_cnt)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Requester side: pending entries held stable until accepted.
   bit         pend  [N];
   logic [W-1:0] pdata [N];
   int         waits [N];

   // Reference model of the output slot.
   bit          mv;
   logic [W-1:0] md;
   int          ms;
   int unsigned mcnt;
   int          mptr;
   bit          m_ready_r;
   bit          af_r;
   int          last_win;

   function automatic logic [W-1:0] rand_entry();
      logic [W-1:0] d;
      d = '0;
      for (int j = 0; j < W / 32; j++) d[j*32 +: 32] = $urandom();
      d[W-1 -: 8] = 8'($urandom());
      return d;
   endfunction

   task automatic model_reset();
      mv = 1'b0; md = '0; ms = 0; mcnt = 0; mptr = 0;
   endtask

   task automatic refill(input int pct);
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && ($urandom_range(99) < pct)) begin
            pend[i]  = 1'b1;
            pdata[i] = rand_entry();
            waits[i] = 0;
         end
      end
   endtask

   task automatic clear_pend();
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
   endtask

   // One clock: drive inputs, check grant, advance model, check slot outputs.
   task automatic tick();
      int w;
      bit can;
      logic [N-1:0] exp_rdy;
      logic [W-1:0] exp_d;
      for (int i = 0; i < N; i++) begin
         s_req_valid[i]       = pend[i];
         s_req_data[i*W +: W] = pdata[i];
      end
      m_req_ready = m_ready_r;
      af          = af_r;
      #2;
      can = (!mv || m_ready_r) && !af_r;
      w = -1;
      for (int k = 0; k < N; k++) begin
         if (w < 0 && pend[(mptr + k) % N]) w = (mptr + k) % N;
      end
      if (!can) w = -1;
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      n_cmp++;
      if (s_req_ready !== exp_rdy) begin
         n_err++;
         $display("FAIL ready t=%0t: got %b expected %b", $time, s_req_ready, exp_rdy);
      end
      @(posedge clk);
      #1;
      if (mv && m_ready_r) mcnt++;
      if (w >= 0) begin
         exp_d = pdata[w];
         exp_d[31 -: IDB] = IDB'(w);
         md = exp_d; mv = 1'b1; ms = w; mptr = (w + 1) % N;
         pend[w] = 1'b0;
         n_cmp++;
         if (waits[w] > N - 1) begin
            n_err++;
            $display("FAIL fairness req%0d: waited %0d accepts, limit %0d", w, waits[w], N - 1);
         end
         waits[w] = 0;
         for (int j = 0; j < N; j++) if (pend[j]) waits[j]++;
      end else if (mv && m_ready_r) begin
         mv = 1'b0;
      end
      last_win = w;
      n_cmp++;
      if (m_req_valid !== mv) begin
         n_err++;
         $display("FAIL valid t=%0t: got %b expected %b", $time, m_req_valid, mv);
      end
      if (mv) begin
         n_cmp++;
         if (m_req_src !== IDB'(ms)) begin
            n_err++;
            $display("FAIL src t=%0t: got %0d expected %0d", $time, m_req_src, ms);
         end
         n_cmp++;
         if (m_req_data !== md) begin
            n_err++;
            $display("FAIL data t=%0t: got %h expected %h", $time, m_req_data, md);
         end
      end
      n_cmp++;
      if (o_issued_cnt !== mcnt) begin
         n_err++;
         $display("FAIL issued_cnt t=%0t: got %0d expected %0d", $time, o_issued_cnt, mcnt);
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      s_req_valid = '0; s_req_data = '0; m_req_ready = 1'b0; af = 1'b0;
      clear_pend();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (m_req_valid !== 1'b0 || o_issued_cnt !== 32'd0 || m_req_src !== '0 || m_req_data !== '0) begin
         n_err++;
         $display("FAIL reset_state: valid=%b cnt=%0d src=%0d data=%h expected all zero",
                  m_req_valid, o_issued_cnt, m_req_src, m_req_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_ready_r = 1'b1; af_r = 1'b0;
      repeat (3) begin refill(100); tick(); end
      m_ready_r = 1'b0;
      refill(100); tick();
      refill(100); tick();
      // Slot is full with a nonzero count: reset must clear it immediately.
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (m_req_valid !== 1'b0 || o_issued_cnt !== 32'd0) begin
         n_err++;
         $display("FAIL midstream_reset: valid=%b cnt=%0d expected 0/0", m_req_valid, o_issued_cnt);
      end
      n_cmp++;
      if (s_req_ready !== '0) begin
         n_err++;
         $display("FAIL reset_ready: got %b expected 0000", s_req_ready);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      m_ready_r = 1'b1;
      refill(100);
      tick();
      n_cmp++;
      if (m_req_src !== IDB'(0) || last_win != 0) begin
         n_err++;
         $display("FAIL first_grant_after_reset: got src %0d expected 0", m_req_src);
      end
   endtask

   task automatic test_single();
      logic [W-1:0] e;
      int unsigned c0;
      clear_pend();
      m_ready_r = 1'b1; af_r = 1'b0;
      tick(); tick();
      e = rand_entry();
      e[31:16] = 16'h1234;
      pend[1] = 1'b1; pdata[1] = e; waits[1] = 0;
      c0 = o_issued_cnt;
      tick();
      n_cmp++;
      if (m_req_valid !== 1'b1 || m_req_src !== IDB'(1) || m_req_data[31:16] !== 16'h5234) begin
         n_err++;
         $display("FAIL single_req: valid=%b src=%0d cid=%h expected 1/1/5234",
                  m_req_valid, m_req_src, m_req_data[31:16]);
      end
      tick();
      n_cmp++;
      if (o_issued_cnt !== c0 + 1 || m_req_valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_issue: cnt=%0d valid=%b expected %0d/0", o_issued_cnt, m_req_valid, c0 + 1);
      end
   endtask

   task automatic test_all_four();
      clear_pend();
      pulse_reset();
      m_ready_r = 1'b1; af_r = 1'b0;
      for (int k = 0; k < 8; k++) begin
         refill(100);
         tick();
         n_cmp++;
         if (m_req_valid !== 1'b1 || m_req_src !== IDB'(k % N)) begin
            n_err++;
            $display("FAIL rr_order step %0d: valid=%b src=%0d expected 1/%0d", k, m_req_valid, m_req_src, k % N);
         end
      end
      clear_pend();
      tick();
      n_cmp++;
      if (o_issued_cnt !== 32'd8) begin
         n_err++;
         $display("FAIL rr_count: got %0d expected 8", o_issued_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] held;
      logic [W-1:0] e2;
      clear_pend();
      m_ready_r = 1'b1; af_r = 1'b0;
      pend[0] = 1'b1; pdata[0] = rand_entry(); waits[0] = 0;
      tick();
      held = m_req_data;
      e2 = rand_entry();
      pend[2] = 1'b1; pdata[2] = e2; waits[2] = 0;
      m_ready_r = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++;
         if (m_req_data !== held || s_req_ready !== '0) begin
            n_err++;
            $display("FAIL backpressure cycle %0d: ready=%b data_changed=%b", k, s_req_ready, m_req_data !== held);
         end
      end
      m_ready_r = 1'b1;
      tick();
      e2[31 -: IDB] = IDB'(2);
      n_cmp++;
      if (m_req_valid !== 1'b1 || m_req_src !== IDB'(2) || m_req_data !== e2) begin
         n_err++;
         $display("FAIL bp_reload: valid=%b src=%0d data=%h expected src 2 data %h",
                  m_req_valid, m_req_src, m_req_data, e2);
      end
   endtask

   task automatic test_almost_full();
      int unsigned c0;
      clear_pend();
      m_ready_r = 1'b1; af_r = 1'b0;
      tick();
      pend[1] = 1'b1; pdata[1] = rand_entry(); waits[1] = 0;
      tick();
      pend[3] = 1'b1; pdata[3] = rand_entry(); waits[3] = 0;
      af_r = 1'b1; m_ready_r = 1'b0;
      tick();
      n_cmp++;
      if (m_req_valid !== 1'b1 || m_req_src !== IDB'(1)) begin
         n_err++;
         $display("FAIL af_hold: valid=%b src=%0d expected 1/1", m_req_valid, m_req_src);
      end
      c0 = o_issued_cnt;
      m_ready_r = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (m_req_valid !== 1'b0 || s_req_ready !== '0 || o_issued_cnt !== c0 + 1) begin
         n_err++;
         $display("FAIL af_block: valid=%b ready=%b cnt=%0d expected 0/0000/%0d",
                  m_req_valid, s_req_ready, o_issued_cnt, c0 + 1);
      end
      af_r = 1'b0;
      tick();
      n_cmp++;
      if (m_req_valid !== 1'b1 || m_req_src !== IDB'(3)) begin
         n_err++;
         $display("FAIL af_resume: valid=%b src=%0d expected 1/3", m_req_valid, m_req_src);
      end
   endtask

   task automatic test_wrap();
      clear_pend();
      pulse_reset();
      m_ready_r = 1'b1; af_r = 1'b0;
      pend[2] = 1'b1; pdata[2] = rand_entry(); waits[2] = 0;
      tick();
      pend[0] = 1'b1; pdata[0] = rand_entry(); waits[0] = 0;
      pend[3] = 1'b1; pdata[3] = rand_entry(); waits[3] = 0;
      tick();
      n_cmp++;
      if (m_req_src !== IDB'(3)) begin
         n_err++;
         $display("FAIL wrap_first: got src %0d expected 3", m_req_src);
      end
      tick();
      n_cmp++;
      if (m_req_src !== IDB'(0) || m_req_valid !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_second: got src %0d valid %b expected 0/1", m_req_src, m_req_valid);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         refill(40);
         m_ready_r = ($urandom_range(3) != 0);
         af_r      = ($urandom_range(4) == 0);
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_backpressure();
      test_almost_full();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
